// File: rtl/uart_word_tx.sv
// uart_word_tx: serialises a DATAWIDTH-bit word as back-to-back UART byte
// frames (start, 8 data bits LSB first, optional parity, 1 or 2 stop bits).
// The word is latched on accept so tx_data may change while a word is in flight.
// byte_done is registered one clock early so that it lines up with the last
// stop-bit clock; this relies on BPS_CNT being at least 2.
`timescale 1ns/1ps

module uart_word_tx #(
    parameter int CLK_FREQ       = 200000000,
    parameter int UART_BPS       = 115200,
    parameter int DATAWIDTH      = 16,
    parameter int PARITY         = 0,
    parameter int STOP_BITS      = 1,
    parameter int MSB_FIRST_BYTE = 0
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic                 tx_valid,
    input  logic [DATAWIDTH-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx_busy,
    output logic                 uart_txd,
    output logic                 byte_done,
    output logic                 word_done
);

    localparam int BPS_CNT   = CLK_FREQ / UART_BPS;
    localparam int NUM_BYTES = DATAWIDTH / 8;
    localparam int CNT_W     = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
    localparam int IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(BPS_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_PENULT = CNT_W'(BPS_CNT - 2);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_BYTES - 1);
    localparam logic             STOP_LAST  = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } state_t;

    state_t                 state;
    logic [CNT_W-1:0]       bit_cnt;
    logic [2:0]             bit_idx;
    logic                   stop_idx;
    logic [IDX_W-1:0]       byte_idx;
    logic [DATAWIDTH-1:0]   word_reg;
    logic [7:0]             shift_reg;
    logic                   parity_bit;

    // Byte number idx of the transmit order, honouring MSB_FIRST_BYTE.
    function automatic logic [7:0] pick_byte(input logic [DATAWIDTH-1:0] w,
                                             input logic [IDX_W-1:0]     idx);
        logic [7:0] b;
        int         sel;
        b   = 8'h00;
        sel = (MSB_FIRST_BYTE != 0) ? (NUM_BYTES - 1 - int'(idx)) : int'(idx);
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (i == sel) begin
                b = w[8*i +: 8];
            end
        end
        return b;
    endfunction

    // Odd mode makes the total count of ones odd, even mode makes it even.
    function automatic logic calc_parity(input logic [7:0] d);
        return (PARITY == 1) ? ~^d : ^d;
    endfunction

    assign tx_busy = ~tx_ready;

    // Frame sequencer: bit timing, byte stepping, line drive and done pulses.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            byte_idx   <= '0;
            word_reg   <= '0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
            uart_txd   <= 1'b1;
            tx_ready   <= 1'b1;
            byte_done  <= 1'b0;
            word_done  <= 1'b0;
        end else begin
            byte_done <= (state == STOP) && (stop_idx == STOP_LAST) && (bit_cnt == CNT_PENULT);
            word_done <= (state == STOP) && (stop_idx == STOP_LAST) && (bit_cnt == CNT_PENULT)
                         && (byte_idx == IDX_LAST);

            if (state == IDLE) begin
                uart_txd <= 1'b1;
                tx_ready <= 1'b1;
                bit_cnt  <= '0;
                if (tx_valid) begin
                    word_reg   <= tx_data;
                    shift_reg  <= pick_byte(tx_data, '0);
                    parity_bit <= calc_parity(pick_byte(tx_data, '0));
                    byte_idx   <= '0;
                    uart_txd   <= 1'b0;
                    tx_ready   <= 1'b0;
                    state      <= START;
                end
            end else if (bit_cnt != CNT_LAST) begin
                bit_cnt <= bit_cnt + CNT_W'(1);
            end else begin
                bit_cnt <= '0;
                case (state)
                    START: begin
                        bit_idx   <= '0;
                        uart_txd  <= shift_reg[0];
                        shift_reg <= {1'b0, shift_reg[7:1]};
                        state     <= DATA;
                    end
                    DATA: begin
                        if (bit_idx == 3'd7) begin
                            if (PARITY != 0) begin
                                uart_txd <= parity_bit;
                                state    <= PAR;
                            end else begin
                                uart_txd <= 1'b1;
                                stop_idx <= 1'b0;
                                state    <= STOP;
                            end
                        end else begin
                            bit_idx   <= bit_idx + 3'd1;
                            uart_txd  <= shift_reg[0];
                            shift_reg <= {1'b0, shift_reg[7:1]};
                        end
                    end
                    PAR: begin
                        uart_txd <= 1'b1;
                        stop_idx <= 1'b0;
                        state    <= STOP;
                    end
                    STOP: begin
                        if (stop_idx != STOP_LAST) begin
                            stop_idx <= 1'b1;
                            uart_txd <= 1'b1;
                        end else if (byte_idx == IDX_LAST) begin
                            uart_txd <= 1'b1;
                            tx_ready <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            byte_idx   <= byte_idx + IDX_W'(1);
                            shift_reg  <= pick_byte(word_reg, byte_idx + IDX_W'(1));
                            parity_bit <= calc_parity(pick_byte(word_reg, byte_idx + IDX_W'(1)));
                            uart_txd   <= 1'b0;
                            state      <= START;
                        end
                    end
                    default: begin
                        uart_txd <= 1'b1;
                        tx_ready <= 1'b1;
                        state    <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_word_tx.sv
// tb_uart_word_tx: directed checks of uart_word_tx at 10 clocks per bit.
// Five instances cover plain 16-bit, even/odd parity, two stop bits and
// MSB-first byte order; each word's line is captured clock by clock and
// compared against a frame built independently from the byte values.
`timescale 1ns/1ps

module tb_uart_word_tx;

    localparam int BPS  = 10;
    localparam int NCAP = 420;
    localparam int NDUT = 5;

    logic        sys_clk;
    logic        sys_rst_n;
    logic        valid [NDUT];
    logic [15:0] data  [NDUT];
    logic        txd   [NDUT];
    logic        rdy   [NDUT];
    logic        bsy   [NDUT];
    logic        bd    [NDUT];
    logic        wd    [NDUT];

    logic cap_txd [NCAP];
    logic cap_rdy [NCAP];
    logic cap_bsy [NCAP];
    logic cap_bd  [NCAP];
    logic cap_wd  [NCAP];
    logic exp_txd [NCAP];
    int   exp_len;
    int   bd_pos[$];
    int   wd_pos[$];
    int   rdy_low;

    int total_checks;
    int bad_checks;

    // Free-running 100 MHz clock.
    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    uart_word_tx #(.CLK_FREQ(1000000), .UART_BPS(100000), .DATAWIDTH(16), .PARITY(0),
                   .STOP_BITS(1), .MSB_FIRST_BYTE(0)) dut_main (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .tx_valid(valid[0]), .tx_data(data[0]),
        .tx_ready(rdy[0]), .tx_busy(bsy[0]), .uart_txd(txd[0]), .byte_done(bd[0]), .word_done(wd[0]));

    uart_word_tx #(.CLK_FREQ(1000000), .UART_BPS(100000), .DATAWIDTH(8), .PARITY(2),
                   .STOP_BITS(1), .MSB_FIRST_BYTE(0)) dut_even (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .tx_valid(valid[1]), .tx_data(data[1][7:0]),
        .tx_ready(rdy[1]), .tx_busy(bsy[1]), .uart_txd(txd[1]), .byte_done(bd[1]), .word_done(wd[1]));

    uart_word_tx #(.CLK_FREQ(1000000), .UART_BPS(100000), .DATAWIDTH(8), .PARITY(1),
                   .STOP_BITS(1), .MSB_FIRST_BYTE(0)) dut_odd (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .tx_valid(valid[2]), .tx_data(data[2][7:0]),
        .tx_ready(rdy[2]), .tx_busy(bsy[2]), .uart_txd(txd[2]), .byte_done(bd[2]), .word_done(wd[2]));

    uart_word_tx #(.CLK_FREQ(1000000), .UART_BPS(100000), .DATAWIDTH(8), .PARITY(0),
                   .STOP_BITS(2), .MSB_FIRST_BYTE(0)) dut_stop2 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .tx_valid(valid[3]), .tx_data(data[3][7:0]),
        .tx_ready(rdy[3]), .tx_busy(bsy[3]), .uart_txd(txd[3]), .byte_done(bd[3]), .word_done(wd[3]));

    uart_word_tx #(.CLK_FREQ(1000000), .UART_BPS(100000), .DATAWIDTH(16), .PARITY(0),
                   .STOP_BITS(1), .MSB_FIRST_BYTE(1)) dut_msb (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .tx_valid(valid[4]), .tx_data(data[4]),
        .tx_ready(rdy[4]), .tx_busy(bsy[4]), .uart_txd(txd[4]), .byte_done(bd[4]), .word_done(wd[4]));

    // Bound the whole run in case a wait never completes.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input int observed, input int expected);
        total_checks++;
        assert (observed === expected)
        else begin
            bad_checks++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic record(input int inst, input int k);
        cap_txd[k] = txd[inst];
        cap_rdy[k] = rdy[inst];
        cap_bsy[k] = bsy[inst];
        cap_bd[k]  = bd[inst];
        cap_wd[k]  = wd[inst];
    endtask

    // Offer a word, then capture n samples starting with the accept edge.
    task automatic apply_stimulus(input int inst, input logic [15:0] word, input logic [15:0] late_word,
                                  input bit hold, input int poke_at, input int n);
        valid[inst] = 1'b1;
        data[inst]  = word;
        @(posedge sys_clk); #1;
        for (int k = 0; k < n; k++) begin
            record(inst, k);
            if (k == 0) begin
                data[inst]  = late_word;
                valid[inst] = hold;
            end
            if (poke_at >= 0 && k == poke_at) begin
                valid[inst] = 1'b1;
                data[inst]  = 16'hFFFF;
            end else if (poke_at >= 0 && k == poke_at + 1) begin
                valid[inst] = 1'b0;
            end
            if (k == n - 1) valid[inst] = 1'b0;
            @(posedge sys_clk); #1;
        end
    endtask

    task automatic capture_idle(input int inst, input int n);
        for (int k = 0; k < n; k++) begin
            record(inst, k);
            @(posedge sys_clk); #1;
        end
    endtask

    task automatic start_expect();
        for (int i = 0; i < NCAP; i++) exp_txd[i] = 1'b1;
        exp_len = 0;
    endtask

    task automatic add_bit(input logic v);
        for (int i = 0; i < BPS; i++) begin
            exp_txd[exp_len] = v;
            exp_len++;
        end
    endtask

    task automatic add_byte(input logic [7:0] b, input int par, input int stops);
        add_bit(1'b0);
        for (int i = 0; i < 8; i++) add_bit(b[i]);
        if (par == 1) add_bit(~^b);
        else if (par == 2) add_bit(^b);
        for (int s = 0; s < stops; s++) add_bit(1'b1);
    endtask

    function automatic int line_errors(input int n);
        int errs;
        errs = 0;
        for (int i = 0; i < n; i++) begin
            if (cap_txd[i] !== exp_txd[i]) errs++;
        end
        return errs;
    endfunction

    task automatic analyze(input int n);
        bd_pos.delete();
        wd_pos.delete();
        rdy_low = 0;
        for (int i = 0; i < n; i++) begin
            if (cap_bd[i] === 1'b1) bd_pos.push_back(i);
            if (cap_wd[i] === 1'b1) wd_pos.push_back(i);
            if (cap_rdy[i] === 1'b0) rdy_low++;
        end
    endtask

    function automatic int pos_at(input int q[$], input int idx);
        return (idx < q.size()) ? q[idx] : -1;
    endfunction

    task automatic wait_idle(input int inst);
        for (int i = 0; i < 50 && rdy[inst] !== 1'b1; i++) begin
            @(posedge sys_clk); #1;
        end
        check_output("idle_wait", int'(rdy[inst]), 1);
    endtask

    // Directed sequence.
    initial begin
        total_checks = 0;
        bad_checks   = 0;
        sys_rst_n    = 1'b0;
        for (int i = 0; i < NDUT; i++) begin
            valid[i] = 1'b0;
            data[i]  = 16'h0000;
        end

        $display("[TB] reset state");
        @(posedge sys_clk); @(posedge sys_clk); #1;
        check_output("rst_txd", int'(txd[0]), 1);
        check_output("rst_ready", int'(rdy[0]), 1);
        check_output("rst_busy", int'(bsy[0]), 0);
        check_output("rst_byte_done", int'(bd[0]), 0);
        check_output("rst_word_done", int'(wd[0]), 0);
        sys_rst_n = 1'b1;
        @(posedge sys_clk); #1;
        check_output("idle_txd_no_valid", int'(txd[0]), 1);

        $display("[TB] 16-bit word A55A, ignored offer mid-word");
        apply_stimulus(0, 16'hA55A, 16'h0000, 1'b0, 50, 210);
        start_expect();
        add_byte(8'h5A, 0, 1);
        add_byte(8'hA5, 0, 1);
        analyze(210);
        check_output("a55a_line_errs", line_errors(210), 0);
        check_output("a55a_start_low", int'(cap_txd[0]), 0);
        check_output("a55a_busy_c0", int'(cap_bsy[0]), 1);
        check_output("a55a_ready_low", rdy_low, 200);
        check_output("a55a_ready_c199", int'(cap_rdy[199]), 0);
        check_output("a55a_ready_c200", int'(cap_rdy[200]), 1);
        check_output("a55a_bd_count", bd_pos.size(), 2);
        check_output("a55a_bd0", pos_at(bd_pos, 0), 99);
        check_output("a55a_bd1", pos_at(bd_pos, 1), 199);
        check_output("a55a_wd_count", wd_pos.size(), 1);
        check_output("a55a_wd0", pos_at(wd_pos, 0), 199);
        wait_idle(0);

        $display("[TB] even parity 0x07");
        apply_stimulus(1, 16'h0007, 16'h00F0, 1'b0, -1, 115);
        start_expect();
        add_byte(8'h07, 2, 1);
        analyze(115);
        check_output("even_parity_bit", int'(cap_txd[95]), 1);
        check_output("even_line_errs", line_errors(115), 0);
        check_output("even_ready_low", rdy_low, 110);
        check_output("even_bd0", pos_at(bd_pos, 0), 109);
        check_output("even_wd0", pos_at(wd_pos, 0), 109);
        wait_idle(1);

        $display("[TB] odd parity 0x07");
        apply_stimulus(2, 16'h0007, 16'h00F0, 1'b0, -1, 115);
        start_expect();
        add_byte(8'h07, 1, 1);
        analyze(115);
        check_output("odd_parity_bit", int'(cap_txd[95]), 0);
        check_output("odd_line_errs", line_errors(115), 0);
        check_output("odd_ready_low", rdy_low, 110);
        wait_idle(2);

        $display("[TB] two stop bits 0x00");
        apply_stimulus(3, 16'h0000, 16'h00FF, 1'b0, -1, 115);
        start_expect();
        add_byte(8'h00, 0, 2);
        analyze(115);
        begin
            int highs;
            highs = 0;
            for (int i = 90; i < 110; i++) if (cap_txd[i] === 1'b1) highs++;
            check_output("stop2_high_clocks", highs, 20);
        end
        check_output("stop2_last_data_low", int'(cap_txd[89]), 0);
        check_output("stop2_line_errs", line_errors(115), 0);
        check_output("stop2_ready_low", rdy_low, 110);
        check_output("stop2_bd0", pos_at(bd_pos, 0), 109);
        wait_idle(3);

        $display("[TB] MSB-first 0x1234");
        apply_stimulus(4, 16'h1234, 16'h0000, 1'b0, -1, 205);
        start_expect();
        add_byte(8'h12, 0, 1);
        add_byte(8'h34, 0, 1);
        analyze(205);
        check_output("msb_first_bit0", int'(cap_txd[15]), 0);
        check_output("msb_first_bit1", int'(cap_txd[25]), 1);
        check_output("msb_second_start", int'(cap_txd[100]), 0);
        check_output("msb_line_errs", line_errors(205), 0);
        check_output("msb_wd0", pos_at(wd_pos, 0), 199);
        wait_idle(4);

        $display("[TB] held valid, data changes after accept");
        apply_stimulus(0, 16'h1111, 16'h2222, 1'b1, -1, 401);
        start_expect();
        add_byte(8'h11, 0, 1);
        add_byte(8'h11, 0, 1);
        exp_len++;
        add_byte(8'h22, 0, 1);
        add_byte(8'h22, 0, 1);
        analyze(401);
        check_output("hold_line_errs", line_errors(401), 0);
        check_output("hold_idle_c200_txd", int'(cap_txd[200]), 1);
        check_output("hold_ready_c200", int'(cap_rdy[200]), 1);
        check_output("hold_ready_c201", int'(cap_rdy[201]), 0);
        check_output("hold_ready_low", rdy_low, 400);
        check_output("hold_wd_count", wd_pos.size(), 2);
        wait_idle(0);

        $display("[TB] reset mid-word at clock 55");
        apply_stimulus(0, 16'hC3C3, 16'h0000, 1'b0, -1, 55);
        sys_rst_n = 1'b0;
        #1;
        check_output("midrst_txd", int'(txd[0]), 1);
        check_output("midrst_ready", int'(rdy[0]), 1);
        check_output("midrst_busy", int'(bsy[0]), 0);
        check_output("midrst_byte_done", int'(bd[0]), 0);
        check_output("midrst_word_done", int'(wd[0]), 0);
        @(posedge sys_clk); #1;
        @(posedge sys_clk); #1;
        sys_rst_n = 1'b1;
        capture_idle(0, 20);
        start_expect();
        analyze(20);
        check_output("postrst_line_errs", line_errors(20), 0);
        check_output("postrst_bd_count", bd_pos.size(), 0);
        check_output("postrst_wd_count", wd_pos.size(), 0);
        check_output("postrst_ready_low", rdy_low, 0);

        apply_stimulus(0, 16'h00FF, 16'h0000, 1'b0, -1, 205);
        start_expect();
        add_byte(8'hFF, 0, 1);
        add_byte(8'h00, 0, 1);
        analyze(205);
        check_output("w00ff_line_errs", line_errors(205), 0);
        check_output("w00ff_ready_low", rdy_low, 200);
        check_output("w00ff_bd0", pos_at(bd_pos, 0), 99);
        check_output("w00ff_bd1", pos_at(bd_pos, 1), 199);
        check_output("w00ff_wd0", pos_at(wd_pos, 0), 199);
        wait_idle(0);

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
